// File: rtl/systolic_conv_seq.sv
// rtl/systolic_conv_seq.sv - weight-load / skewed-stream sequencer for a ROWS x COLS systolic array
module systolic_conv_seq #(
    parameter int ROWS  = 32,
    parameter int COLS  = 32,
    parameter int LEN_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       stall,
    input  logic [$clog2(ROWS+1)-1:0]  act_rows,
    input  logic [$clog2(COLS+1)-1:0]  act_cols,
    input  logic [LEN_W-1:0]           vec_len,
    output logic                       w_ps,
    output logic [$clog2(ROWS)-1:0]    load_row,
    output logic [ROWS-1:0]            input_en,
    output logic [COLS-1:0]            out_en,
    output logic                       busy,
    output logic                       conv_finish,
    output logic                       cfg_err
);
    localparam int RW  = $clog2(ROWS+1);
    localparam int CW  = $clog2(COLS+1);
    localparam int LRW = $clog2(ROWS);
    localparam int TW  = LEN_W + $clog2(ROWS+COLS) + 1;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DONE} state_t;

    state_t           state, state_n;
    logic [RW-1:0]    rows_q, rows_n;
    logic [CW-1:0]    cols_q, cols_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [LRW-1:0]   cnt, cnt_n;
    logic [TW-1:0]    t, t_n;
    logic             cfg_err_q, cfg_err_n;
    logic [TW-1:0]    t_last;
    logic             cfg_bad;

    assign t_last  = TW'(rows_q) + TW'(cols_q) + TW'(len_q) - TW'(2);
    assign cfg_bad = (act_rows == '0) || (act_rows > RW'(ROWS)) ||
                     (act_cols == '0) || (act_cols > CW'(COLS)) ||
                     (vec_len == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            t         <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            rows_q    <= rows_n;
            cols_q    <= cols_n;
            len_q     <= len_n;
            cnt       <= cnt_n;
            t         <= t_n;
            cfg_err_q <= cfg_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        rows_n    = rows_q;
        cols_n    = cols_q;
        len_n     = len_q;
        cnt_n     = '0;
        t_n       = t;
        cfg_err_n = 1'b0;
        case (state)
            IDLE: begin
                t_n = '0;
                if (start) begin
                    rows_n = act_rows;
                    cols_n = act_cols;
                    len_n  = vec_len;
                    if (cfg_bad) cfg_err_n = 1'b1;
                    else         state_n   = LOAD_W;
                end
            end
            LOAD_W: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (RW'(cnt) == rows_q - RW'(1)) begin
                    state_n = STREAM;
                    t_n     = '0;
                end else begin
                    cnt_n = cnt + LRW'(1);
                end
            end
            STREAM: begin
                if (abort) begin
                    state_n = IDLE;
                    t_n     = '0;
                end else if (stall) begin
                    t_n = t;
                end else if (t == t_last) begin
                    state_n = DONE;
                    t_n     = '0;
                end else begin
                    t_n = t + TW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Row r streams during [r, r+len); column c drains during [rows+c, rows+c+len).
    always_comb begin
        input_en = '0;
        out_en   = '0;
        if (state == STREAM && !stall) begin
            for (int r = 0; r < ROWS; r++) begin
                if (TW'(r) < TW'(rows_q) && t >= TW'(r) && t < TW'(r) + TW'(len_q))
                    input_en[r] = 1'b1;
            end
            for (int c = 0; c < COLS; c++) begin
                if (TW'(c) < TW'(cols_q) && t >= TW'(rows_q) + TW'(c) &&
                    t < TW'(rows_q) + TW'(c) + TW'(len_q))
                    out_en[c] = 1'b1;
            end
        end
    end

    assign w_ps        = (state != STREAM);
    assign load_row    = cnt;
    assign busy        = (state != IDLE);
    assign conv_finish = (state == DONE);
    assign cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_systolic_conv_seq.sv
// tb/tb_systolic_conv_seq.sv - randomized self-checking bench for systolic_conv_seq
module tb_systolic_conv_seq;
    localparam int ROWS = 4, COLS = 4, LEN_W = 4;

    logic       clk = 1'b0;
    logic       rst, start, abort, stall;
    logic [2:0] act_rows, act_cols;
    logic [3:0] vec_len;
    logic       w_ps;
    logic [1:0] load_row;
    logic [3:0] input_en, out_en;
    logic       busy, conv_finish, cfg_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_conv_seq #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
        .act_rows(act_rows), .act_cols(act_cols), .vec_len(vec_len),
        .w_ps(w_ps), .load_row(load_row), .input_en(input_en), .out_en(out_en),
        .busy(busy), .conv_finish(conv_finish), .cfg_err(cfg_err)
    );

    // {w_ps, load_row, input_en, out_en, busy, conv_finish, cfg_err}
    logic [14:0] obs;
    assign obs = {w_ps, load_row, input_en, out_en, busy, conv_finish, cfg_err};
    localparam logic [14:0] IDLE_V = 15'b1_00_0000_0000_000;
    localparam logic [14:0] CERR_V = 15'b1_00_0000_0000_001;

    function automatic logic [3:0] ien_m(int t, int r, int l);
        for (int i = 0; i < 4; i++) ien_m[i] = (i < r) && (t >= i) && (t < i + l);
    endfunction

    function automatic logic [3:0] oen_m(int t, int r, int c, int l);
        for (int i = 0; i < 4; i++) oen_m[i] = (i < c) && (t >= r + i) && (t < r + i + l);
    endfunction

    // smode: 0 no stall, 1 random stall, 2 two stall cycles at t=3. abort_k: cycle to abort, -1 none.
    task automatic run_pass(input string nm, input int r, input int c, input int l,
                            input int smode, input int abort_k, input bit abort0,
                            output int fin_k);
        int t = 0, nst = 0, last = r + c + l - 2;
        bit fin = 0, ab_prev = 0, st, in_stream;
        logic [14:0] e;
        fin_k = -1;
        @(posedge clk); #1;
        start = 1; abort = abort0; stall = (smode == 1) ? 1'($urandom % 2) : 1'b0;
        act_rows = 3'(r); act_cols = 3'(c); vec_len = 4'(l);
        #1;
        checks++;
        if (obs !== IDLE_V) begin
            failures++; $display("FAIL %s cycle0 got=%b exp=%b", nm, obs, IDLE_V);
        end
        for (int k = 1; k <= 120 && !fin; k++) begin
            @(posedge clk); #1;
            in_stream = (k > r) && (t <= last) && !ab_prev;
            start    = ab_prev ? 1'b0 : 1'($urandom % 2);
            abort    = (k == abort_k);
            act_rows = 3'($urandom); act_cols = 3'($urandom); vec_len = 4'($urandom);
            case (smode)
                1:       stall = ($urandom % 4 == 0);
                2:       stall = in_stream && t == 3 && nst < 2;
                default: stall = 1'b0;
            endcase
            st = in_stream && stall;
            #1;
            if (ab_prev)        e = IDLE_V;
            else if (k <= r)    e = {1'b1, 2'(k - 1), 8'b0, 3'b100};
            else if (t <= last) e = {1'b0, 2'b0, st ? 4'b0 : ien_m(t, r, l),
                                     st ? 4'b0 : oen_m(t, r, c, l), 3'b100};
            else                e = {1'b1, 2'b0, 8'b0, 3'b110};
            checks++;
            if (obs !== e) begin
                failures++; $display("FAIL %s cycle%0d t=%0d got=%b exp=%b", nm, k, t, obs, e);
            end
            if (ab_prev) fin = 1;
            else if (!(k <= r) && t > last) begin fin = 1; fin_k = k; end
            else begin
                if (st) nst++;
                if (in_stream && !st) t++;
                ab_prev = abort;
            end
        end
        if (!fin) begin
            failures++; $display("FAIL %s timeout got=running exp=finished", nm);
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 1; abort = 0; stall = 0;
        act_rows = 3'd4; act_cols = 3'd4; vec_len = 4'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            checks++;
            if (obs !== IDLE_V) begin
                failures++; $display("FAIL reset cycle%0d got=%b exp=%b", i, obs, IDLE_V);
            end
        end
        rst = 0; start = 0;
        @(posedge clk); #2;
        checks++;
        if (obs !== IDLE_V) begin
            failures++; $display("FAIL reset_release got=%b exp=%b", obs, IDLE_V);
        end
    endtask

    task automatic test_basic();
        int fk;
        run_pass("basic", 4, 4, 3, 0, -1, 0, fk);
        checks++;
        if (fk !== 15) begin failures++; $display("FAIL basic_finish got=%0d exp=15", fk); end
    endtask

    task automatic test_subarray();
        int fk;
        run_pass("subarray", 2, 3, 1, 0, -1, 0, fk);
        checks++;
        if (fk !== 8) begin failures++; $display("FAIL subarray_finish got=%0d exp=8", fk); end
    endtask

    task automatic test_stall();
        int fk;
        run_pass("stall", 4, 4, 3, 2, -1, 0, fk);
        checks++;
        if (fk !== 17) begin failures++; $display("FAIL stall_finish got=%0d exp=17", fk); end
    endtask

    task automatic test_abort();
        int fk;
        run_pass("abort", 4, 4, 3, 0, 10, 0, fk);
        checks++;
        if (fk !== -1) begin failures++; $display("FAIL abort_finish got=%0d exp=-1", fk); end
        run_pass("after_abort", 4, 4, 3, 0, -1, 0, fk);
        checks++;
        if (fk !== 15) begin failures++; $display("FAIL after_abort_finish got=%0d exp=15", fk); end
    endtask

    task automatic test_cfg_err(input string nm, input int r, input int c, input int l);
        @(posedge clk); #1;
        start = 1; abort = 0; stall = 0;
        act_rows = 3'(r); act_cols = 3'(c); vec_len = 4'(l);
        #1;
        checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL %s c0 got=%b exp=%b", nm, obs, IDLE_V); end
        @(posedge clk); #1; start = 0; #1;
        checks++;
        if (obs !== CERR_V) begin failures++; $display("FAIL %s pulse got=%b exp=%b", nm, obs, CERR_V); end
        @(posedge clk); #2;
        checks++;
        if (obs !== IDLE_V) begin failures++; $display("FAIL %s after got=%b exp=%b", nm, obs, IDLE_V); end
    endtask

    task automatic test_rst_mid_pass();
        int fk;
        @(posedge clk); #1;
        start = 1; abort = 0; stall = 0; act_rows = 3'd4; act_cols = 3'd4; vec_len = 4'd3;
        @(posedge clk); #1; start = 0;
        @(posedge clk); #1;
        rst = 1; start = 1; #1;
        checks++;
        if (obs !== 15'b1_01_0000_0000_100) begin
            failures++; $display("FAIL rst_mid load2 got=%b exp=%b", obs, 15'b1_01_0000_0000_100);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin rst = 0; start = 0; end
            #1;
            checks++;
            if (obs !== IDLE_V) begin
                failures++; $display("FAIL rst_mid idle%0d got=%b exp=%b", i, obs, IDLE_V);
            end
        end
        run_pass("post_rst", 4, 4, 3, 0, -1, 0, fk);
        checks++;
        if (fk !== 15) begin failures++; $display("FAIL post_rst_finish got=%0d exp=15", fk); end
    endtask

    task automatic test_random();
        int r, c, l, fk, ak;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(1, 4); c = $urandom_range(1, 4); l = $urandom_range(1, 6);
            if ($urandom % 5 == 0) begin
                case ($urandom % 4)
                    0: r = ($urandom % 2) ? 0 : $urandom_range(5, 7);
                    1: c = ($urandom % 2) ? 0 : $urandom_range(5, 7);
                    2: l = 0;
                    default: begin r = 0; c = 7; end
                endcase
                test_cfg_err("rand_cfg", r, c, l);
            end else begin
                ak = ($urandom % 4 == 0) ? $urandom_range(1, 2 * r + c + l) : -1;
                run_pass("rand", r, c, l, 1, ak, 1'($urandom % 2), fk);
            end
        end
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; stall = 0;
        act_rows = '0; act_cols = '0; vec_len = '0;
        test_reset();
        test_basic();
        test_subarray();
        test_stall();
        test_abort();
        test_cfg_err("vec_len0", 4, 4, 0);
        test_cfg_err("cols5", 4, 5, 3);
        test_rst_mid_pass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
